// File: rtl/bitty_pkg.sv
// rtl/bitty_pkg.sv - shared state/format encodings and instruction decode for the Bitty control unit
package bitty_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LATCH  = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    MEM    = 3'd5,
    WB     = 3'd6,
    HALT   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    FMT_ALU_R  = 2'b00,
    FMT_ALU_I  = 2'b01,
    FMT_BRANCH = 2'b10,
    FMT_LDST   = 2'b11
  } fmt_t;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef struct packed {
    logic is_halt;
    logic is_alu;
    logic is_branch;
    logic is_ldst;
    logic is_load;
  } dec_t;

  // HALT_WORD overrides its format bits, so every class is masked by is_halt.
  function automatic dec_t decode_ir(input logic [15:0] word);
    dec_t d;
    fmt_t f;
    f           = fmt_t'(word[1:0]);
    d.is_halt   = (word == HALT_WORD);
    d.is_alu    = !d.is_halt && ((f == FMT_ALU_R) || (f == FMT_ALU_I));
    d.is_branch = !d.is_halt && (f == FMT_BRANCH);
    d.is_ldst   = !d.is_halt && (f == FMT_LDST);
    d.is_load   = d.is_ldst && !word[2];
    return d;
  endfunction

endpackage

// File: rtl/bitty_control_unit_if.sv
// rtl/bitty_control_unit_if.sv - datapath-facing signals of the Bitty control unit
interface bitty_control_unit_if;
  logic        run;
  logic [15:0] mem_data;
  logic        alu_done;
  logic        lsu_done;
  logic [15:0] ir;
  logic        en_pc;
  logic        alu_start;
  logic        lsu_start;
  logic        en_rx;
  logic        en_last_result;
  logic [2:0]  state;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  modport master (
    input  run, mem_data, alu_done, lsu_done,
    output ir, en_pc, alu_start, lsu_start, en_rx, en_last_result,
           state, halted, fault, retired
  );

  modport slave (
    output run, mem_data, alu_done, lsu_done,
    input  ir, en_pc, alu_start, lsu_start, en_rx, en_last_result,
           state, halted, fault, retired
  );
endinterface

// File: rtl/bitty_watchdog.sv
// rtl/bitty_watchdog.sv - saturating 8-bit wait counter; expired flags the last allowed wait cycle
module bitty_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // count holds the number of wait cycles already spent, so this is the final one.
  assign expired = enable && (count >= LIMIT);

endmodule

// File: rtl/bitty_control_unit.sv
// rtl/bitty_control_unit.sv - multi-cycle fetch/decode/execute/writeback sequencer; BITTY_SINGLE_STEP_EN adds a step input
module bitty_control_unit
  import bitty_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
`ifdef BITTY_SINGLE_STEP_EN
  input  logic step,
`endif
  bitty_control_unit_if.master bus
);

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] retired_q;
  logic        halted_q;
  logic        fault_q;
  dec_t        dec;
  logic        wd_expired;
  logic        timeout;
  logic        retire;
  logic        go;
  state_t      after_retire;

  assign dec    = decode_ir(ir_q);
  assign retire = ((state_q == DECODE) && dec.is_branch) || (state_q == WB);

`ifdef BITTY_SINGLE_STEP_EN
  assign go           = bus.run && step;
  assign after_retire = IDLE;
`else
  assign go           = bus.run;
  assign after_retire = bus.run ? FETCH : IDLE;
`endif

  bitty_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == DECODE),
    .enable ((state_q == EXEC) || (state_q == MEM)),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == LATCH) ir_q <= bus.mem_data;
      if (retire) retired_q <= retired_q + 16'd1;
      if (state_d == HALT) halted_q <= 1'b1;
      if (timeout) fault_q <= 1'b1;
    end
  end

  // A done in the expiry cycle wins over the watchdog.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      IDLE:   if (go) state_d = FETCH;
      FETCH:  state_d = LATCH;
      LATCH:  state_d = DECODE;
      DECODE: begin
        if (dec.is_halt)        state_d = HALT;
        else if (dec.is_branch) state_d = after_retire;
        else if (dec.is_alu)    state_d = EXEC;
        else                    state_d = MEM;
      end
      EXEC: begin
        if (bus.alu_done) begin
          state_d = WB;
        end else if (wd_expired) begin
          state_d = HALT;
          timeout = 1'b1;
        end
      end
      MEM: begin
        if (bus.lsu_done) begin
          state_d = WB;
        end else if (wd_expired) begin
          state_d = HALT;
          timeout = 1'b1;
        end
      end
      WB:      state_d = after_retire;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ir             = ir_q;
  assign bus.en_pc          = retire;
  assign bus.alu_start      = (state_q == DECODE) && dec.is_alu;
  assign bus.lsu_start      = (state_q == DECODE) && dec.is_ldst;
  assign bus.en_rx          = (state_q == WB) && (dec.is_alu || dec.is_load);
  assign bus.en_last_result = (state_q == WB) && dec.is_alu;
  assign bus.state          = state_q;
  assign bus.halted         = halted_q;
  assign bus.fault          = fault_q;
  assign bus.retired        = retired_q;

endmodule

// File: tb/tb_bitty_control_unit.sv
// tb/tb_bitty_control_unit.sv - randomized scoreboard bench for bitty_control_unit
module tb_bitty_control_unit;

  localparam int T = 15;
  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_EXEC = 4, ST_HALT = 7;
  localparam int K_RETIRE = 0, K_HALTWORD = 1, K_FAULT = 2;

  typedef struct {
    int kind;
    int lat;
    int rx;
    int last;
    int ret;
    int alu_n;
    int lsu_n;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
`ifdef BITTY_SINGLE_STEP_EN
  logic step;
`endif

  bitty_control_unit_if bus ();

  bitty_control_unit #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk  (clk),
    .reset(reset),
`ifdef BITTY_SINGLE_STEP_EN
    .step (step),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   model_retired = 0;
  int   cur_d = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: cycle counts from FETCH (=1) to the retiring or halting cycle.
  function automatic exp_t model(input logic [15:0] w, input int d);
    exp_t e;
    bit   is_alu;
    e = '{default: 0};
    if (w == 16'hFFFF) begin
      e.kind = K_HALTWORD;
      e.lat  = 4;
      e.ret  = model_retired;
    end else if (w[1:0] == 2'b10) begin
      e.lat = 3;
      model_retired = (model_retired + 1) % 65536;
      e.ret = model_retired;
    end else begin
      is_alu  = (w[1] == 1'b0);
      e.alu_n = is_alu ? 1 : 0;
      e.lsu_n = is_alu ? 0 : 1;
      if (d < 0 || d >= T) begin
        e.kind = K_FAULT;
        e.lat  = 3 + T + 1;
        e.ret  = model_retired;
      end else begin
        e.lat  = 5 + d;
        e.rx   = (is_alu || !w[2]) ? 1 : 0;
        e.last = is_alu ? 1 : 0;
        model_retired = (model_retired + 1) % 65536;
        e.ret = model_retired;
      end
    end
    return e;
  endfunction

  // Monitor: samples on the falling edge and pops one expectation per retirement or halt.
  int   m_active = 0, m_cyc = 0, m_alu = 0, m_lsu = 0, m_rx = 0, m_last = 0;
  int   m_pend = 0, m_pend_ret = 0;
  exp_t m_e;

  always @(negedge clk) begin
    if (!reset) begin
      m_active = 0;
      m_pend   = 0;
    end else begin
      if (m_pend != 0) begin
        chk("retired_after", bus.retired, m_pend_ret);
        m_pend = 0;
      end
      if (bus.state == ST_FETCH) begin
        m_active = 1; m_cyc = 1; m_alu = 0; m_lsu = 0; m_rx = 0; m_last = 0;
      end else if (m_active != 0) begin
        m_cyc++;
      end
      if (m_active != 0) begin
        m_alu  += int'(bus.alu_start);
        m_lsu  += int'(bus.lsu_start);
        m_rx   += int'(bus.en_rx);
        m_last += int'(bus.en_last_result);
      end
      if (bus.en_pc) begin
        if (m_active == 0 || sb.size() == 0) begin
          chk("unexpected_retire", 1, 0);
        end else begin
          m_e = sb.pop_front();
          chk("retire_kind", K_RETIRE, m_e.kind);
          chk("latency", m_cyc, m_e.lat);
          chk("en_rx", m_rx, m_e.rx);
          chk("en_last_result", m_last, m_e.last);
          chk("alu_start", m_alu, m_e.alu_n);
          chk("lsu_start", m_lsu, m_e.lsu_n);
          m_pend = 1;
          m_pend_ret = m_e.ret;
        end
        m_active = 0;
      end else if (bus.state == ST_HALT && m_active != 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_halt", 1, 0);
        end else begin
          m_e = sb.pop_front();
          chk("halt_kind", bus.fault ? K_FAULT : K_HALTWORD, m_e.kind);
          chk("halted", bus.halted, 1);
          chk("halt_latency", m_cyc, m_e.lat);
          chk("halt_no_rx", m_rx, 0);
          chk("halt_alu_start", m_alu, m_e.alu_n);
          chk("halt_lsu_start", m_lsu, m_e.lsu_n);
          chk("halt_retired", bus.retired, m_e.ret);
        end
        m_active = 0;
      end
    end
  end

  // Done driver: the matching done fires on wait cycle cur_d; everything else is noise.
  initial begin
    int      idx;
    bit      in_wait;
    bit      hit;
    logic [1:0] noise;
    idx = 0;
    in_wait = 0;
    bus.alu_done = 1'b0;
    bus.lsu_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      noise = 2'($urandom);
      if (bus.state == 3'd4 || bus.state == 3'd5) begin
        idx = in_wait ? idx + 1 : 0;
        in_wait = 1;
      end else begin
        in_wait = 0;
      end
      hit = in_wait && (cur_d >= 0) && (idx == cur_d);
      if (bus.state == 3'd4) begin
        bus.alu_done = hit;
        bus.lsu_done = noise[0];
      end else if (bus.state == 3'd5) begin
        bus.lsu_done = hit;
        bus.alu_done = noise[0];
      end else begin
        bus.alu_done = noise[0];
        bus.lsu_done = noise[1];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s);
    for (int i = 0; i < 80; i++) begin
      if (bus.state == s) break;
      tick();
    end
    chk("wait_state", bus.state, s);
  endtask

  task automatic issue(input logic [15:0] w, input int d);
    wait_state(ST_FETCH);
    bus.mem_data = w;
    cur_d = d;
    sb.push_back(model(w, d));
    tick();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_state"}, bus.state, ST_IDLE);
    chk({tag, "_ir"}, bus.ir, 0);
    chk({tag, "_strobes"}, {bus.en_pc, bus.alu_start, bus.lsu_start, bus.en_rx, bus.en_last_result}, 0);
    chk({tag, "_flags"}, {bus.halted, bus.fault}, 0);
    chk({tag, "_retired"}, bus.retired, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk_cleared(tag);
    model_retired = 0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    reset = 1'b0;
    bus.run = 1'b0;
    bus.mem_data = 16'h0000;
`ifdef BITTY_SINGLE_STEP_EN
    step = 1'b1;
`endif
    #1;
    chk_cleared("reset");
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("idle_without_run", bus.state, ST_IDLE);

    bus.run = 1'b1;
    issue(16'h0002, 0);
    issue(16'h2000, 0);
    issue(16'h0007, 3);
    for (int i = 0; i < 40; i++) begin
      w = 16'($urandom);
      if (w == 16'hFFFF) w = 16'h0000;
      issue(w, int'($urandom_range(0, 6)));
    end
    issue(16'h4001, T - 1);
    issue(16'h000B, T - 1);

    issue(16'h2000, -1);
    wait_state(ST_HALT);
    repeat (3) tick();
    chk("fault_stays_halt", bus.state, ST_HALT);
    chk("fault_flag", bus.fault, 1);
    do_reset("after_fault");

    issue(16'hFFFF, 0);
    wait_state(ST_HALT);
    repeat (5) tick();
    chk("haltword_stays", bus.state, ST_HALT);
    chk("haltword_flags", {bus.halted, bus.fault}, 2'b10);
    do_reset("after_halt");

    issue(16'h2000, -1);
    wait_state(ST_EXEC);
    tick();
    tick();
    void'(sb.pop_back());
    do_reset("reset_in_exec");

    issue(16'hA001, 4);
    wait_state(ST_EXEC);
    bus.run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.en_pc) break;
      tick();
    end
    chk("run_drop_retires", bus.en_pc, 1);
    tick();
    chk("run_drop_idle", bus.state, ST_IDLE);
    repeat (3) tick();
    chk("run_drop_stays_idle", bus.state, ST_IDLE);
    chk("run_drop_retired", bus.retired, model_retired);

`ifdef BITTY_SINGLE_STEP_EN
    step = 1'b0;
    bus.run = 1'b1;
    repeat (3) tick();
    chk("step_low_idle", bus.state, ST_IDLE);
    step = 1'b1;
    tick();
    step = 1'b0;
    issue(16'h6000, 1);
    repeat (12) tick();
    chk("single_step_idle", bus.state, ST_IDLE);
    chk("single_step_retired", bus.retired, model_retired);
`endif

    repeat (2) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
